// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: load wait/align, register-file writeback, exceptions, retire count
module writeback_stage #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        bubble_in,
   input  logic        halt_in,
   input  logic [4:0]  opcode_in,
   input  logic [4:0]  tgt_in_1,
   input  logic [4:0]  tgt_in_2,
   input  logic [31:0] result_in_1,
   input  logic [31:0] result_in_2,
   input  logic [31:0] addr_in,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_misaligned,
   input  logic [1:0]  size_in,
   input  logic        sign_in,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        stall_out,
   output logic        we_1,
   output logic [4:0]  waddr_1,
   output logic [31:0] wdata_1,
   output logic        we_2,
   output logic [4:0]  waddr_2,
   output logic [31:0] wdata_2,
   output logic        exc_out,
   output logic [1:0]  exc_cause,
   output logic        halt_out,
   output logic [31:0] retired
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        cap_valid;
   logic [4:0]  cap_tgt_1, cap_tgt_2;
   logic [31:0] cap_res_2;
   logic [1:0]  cap_off, cap_size;
   logic        cap_sign;

   logic        slot_valid;
   logic        do_alu, do_misal, do_halt, do_ld, ld_done, ld_tmo;
   logic [15:0] half_val;
   logic [7:0]  byte_val;
   logic [31:0] ld_data;

   // Opcode and upper address bits are not needed once decode is done upstream.
   logic unused_ok;
   assign unused_ok = ^{opcode_in, addr_in[31:2]};

   always_comb begin
      state_nxt  = state;
      slot_valid = !bubble_in && !halt_out;
      do_alu     = 1'b0;
      do_misal   = 1'b0;
      do_halt    = 1'b0;
      do_ld      = 1'b0;
      ld_done    = 1'b0;
      ld_tmo     = 1'b0;
      case (state)
         S_IDLE: begin
            if (slot_valid) begin
               if (halt_in)            do_halt  = 1'b1;
               else if (is_misaligned) do_misal = 1'b1;
               else if (is_load) begin
                  do_ld     = 1'b1;
                  state_nxt = S_WAIT;
               end
               else                    do_alu   = 1'b1;
            end
         end
         S_WAIT: begin
            // Response arriving on the timeout edge still completes normally.
            if (!cap_valid) state_nxt = S_IDLE;
            else if (mem_rvalid) begin
               ld_done   = 1'b1;
               state_nxt = S_IDLE;
            end
            else if (cnt == 8'(TIMEOUT - 1)) begin
               ld_tmo    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      half_val = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      byte_val = 8'(mem_rdata >> {cap_off, 3'b000});
      case (cap_size)
         2'b01:   ld_data = {{16{cap_sign & half_val[15]}}, half_val};
         2'b10:   ld_data = {{24{cap_sign & byte_val[7]}}, byte_val};
         default: ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cap_valid <= 1'b0;
         cap_tgt_1 <= '0;
         cap_tgt_2 <= '0;
         cap_res_2 <= '0;
         cap_off   <= '0;
         cap_size  <= '0;
         cap_sign  <= 1'b0;
         stall_out <= 1'b0;
         we_1      <= 1'b0;
         waddr_1   <= '0;
         wdata_1   <= '0;
         we_2      <= 1'b0;
         waddr_2   <= '0;
         wdata_2   <= '0;
         exc_out   <= 1'b0;
         exc_cause <= '0;
         halt_out  <= 1'b0;
         retired   <= '0;
      end
      else if (halt) begin
         // Pulses already delivered must not repeat while frozen.
         we_1      <= 1'b0;
         we_2      <= 1'b0;
         exc_out   <= 1'b0;
         exc_cause <= '0;
      end
      else begin
         state     <= state_nxt;
         stall_out <= (state_nxt == S_WAIT);
         we_1      <= 1'b0;
         we_2      <= 1'b0;
         exc_out   <= 1'b0;
         exc_cause <= '0;
         if (state == S_IDLE) begin
            cap_valid <= slot_valid;
            cap_tgt_1 <= tgt_in_1;
            cap_tgt_2 <= tgt_in_2;
            cap_res_2 <= result_in_2;
            cap_off   <= addr_in[1:0];
            cap_size  <= size_in;
            cap_sign  <= sign_in;
            cnt       <= '0;
         end
         else if (!ld_done && !ld_tmo) begin
            cnt <= cnt + 8'd1;
         end
         if (do_alu) begin
            we_1    <= (tgt_in_1 != 5'd0) && !is_store;
            waddr_1 <= tgt_in_1;
            wdata_1 <= result_in_1;
            we_2    <= (tgt_in_2 != 5'd0);
            waddr_2 <= tgt_in_2;
            wdata_2 <= result_in_2;
         end
         if (ld_done) begin
            we_1    <= (cap_tgt_1 != 5'd0);
            waddr_1 <= cap_tgt_1;
            wdata_1 <= ld_data;
            we_2    <= (cap_tgt_2 != 5'd0);
            waddr_2 <= cap_tgt_2;
            wdata_2 <= cap_res_2;
         end
         if (do_misal) begin
            exc_out   <= 1'b1;
            exc_cause <= 2'b01;
         end
         if (ld_tmo) begin
            exc_out   <= 1'b1;
            exc_cause <= 2'b10;
         end
         if (do_halt) halt_out <= 1'b1;
         if (do_alu || do_misal || do_halt || ld_done || ld_tmo) retired <= retired + 32'd1;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage (TIMEOUT=4)
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst, halt, bubble_in, halt_in;
   logic [4:0]  opcode_in, tgt_in_1, tgt_in_2;
   logic [31:0] result_in_1, result_in_2, addr_in, mem_rdata;
   logic        is_load, is_store, is_misaligned, sign_in, mem_rvalid;
   logic [1:0]  size_in;
   logic        stall_out, we_1, we_2, exc_out, halt_out;
   logic [4:0]  waddr_1, waddr_2;
   logic [31:0] wdata_1, wdata_2, retired;
   logic [1:0]  exc_cause;

   int tests = 0;
   int failed = 0;
   int exp_ret = 0;
   int stalls;

   writeback_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .halt(halt), .bubble_in(bubble_in), .halt_in(halt_in),
      .opcode_in(opcode_in), .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
      .result_in_1(result_in_1), .result_in_2(result_in_2), .addr_in(addr_in),
      .is_load(is_load), .is_store(is_store), .is_misaligned(is_misaligned),
      .size_in(size_in), .sign_in(sign_in), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .stall_out(stall_out), .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
      .we_2(we_2), .waddr_2(waddr_2), .wdata_2(wdata_2), .exc_out(exc_out),
      .exc_cause(exc_cause), .halt_out(halt_out), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic clear_slot();
      bubble_in = 1'b1; halt_in = 1'b0; opcode_in = '0; tgt_in_1 = '0; tgt_in_2 = '0;
      result_in_1 = '0; result_in_2 = '0; addr_in = '0; is_load = 1'b0; is_store = 1'b0;
      is_misaligned = 1'b0; size_in = '0; sign_in = 1'b0;
   endtask

   task automatic set_slot(input logic ld, input logic st, input logic mis, input logic hl,
                           input logic [4:0] t1, input logic [4:0] t2, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] ad, input logic [1:0] sz,
                           input logic sg);
      bubble_in = 1'b0; halt_in = hl; opcode_in = 5'd1; tgt_in_1 = t1; tgt_in_2 = t2;
      result_in_1 = r1; result_in_2 = r2; addr_in = ad; is_load = ld; is_store = st;
      is_misaligned = mis; size_in = sz; sign_in = sg;
   endtask

   task automatic capture();
      @(posedge clk); #1;
      clear_slot();
   endtask

   // Counts stall cycles from capture, raises rvalid for the d-th edge after capture.
   task automatic wait_load(input int d, input logic [31:0] rd, output int n);
      n = 0;
      for (int i = 1; i < d; i++) begin
         if (stall_out === 1'b1) n++;
         @(posedge clk); #1;
      end
      if (stall_out === 1'b1) n++;
      mem_rvalid = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if ({stall_out, we_1, we_2, exc_out, halt_out} !== 5'b0) begin failed++; $display("FAIL reset_flags got %b exp 00000", {stall_out, we_1, we_2, exc_out, halt_out}); end
      tests++; if ({waddr_1, wdata_1, waddr_2, wdata_2, exc_cause} !== '0) begin failed++; $display("FAIL reset_data got %h %h %h %h %b exp 0", waddr_1, wdata_1, waddr_2, wdata_2, exc_cause); end
      tests++; if (retired !== 32'd0) begin failed++; $display("FAIL reset_retired got %0d exp 0", retired); end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      set_slot(0, 0, 0, 0, 5'd3, 5'd0, 32'h1234, 32'h55, 32'h0, 2'b00, 0);
      capture(); exp_ret++;
      tests++; if ({we_1, waddr_1, wdata_1, we_2} !== {1'b1, 5'd3, 32'h1234, 1'b0}) begin failed++; $display("FAIL alu_write got we1=%b a1=%0d d1=%h we2=%b exp 1 3 1234 0", we_1, waddr_1, wdata_1, we_2); end
      tests++; if (retired !== 32'(exp_ret)) begin failed++; $display("FAIL alu_retired got %0d exp %0d", retired, exp_ret); end
      @(posedge clk); #1;
      tests++; if (we_1 !== 1'b0) begin failed++; $display("FAIL alu_one_cycle got we1=%b exp 0", we_1); end
   endtask

   task automatic test_load_align();
      set_slot(1, 0, 0, 0, 5'd7, 5'd0, 32'hDEAD, 32'h0, 32'h1002, 2'b10, 1);
      capture(); exp_ret++;
      wait_load(3, 32'h12F4_5678, stalls);
      tests++; if (stalls != 3) begin failed++; $display("FAIL lb_stall_cycles got %0d exp 3", stalls); end
      tests++; if ({we_1, waddr_1, wdata_1, stall_out} !== {1'b1, 5'd7, 32'hFFFF_FFF4, 1'b0}) begin failed++; $display("FAIL lb_signed got we1=%b a1=%0d d1=%h stall=%b exp 1 7 fffffff4 0", we_1, waddr_1, wdata_1, stall_out); end
      set_slot(1, 0, 0, 0, 5'd7, 5'd0, 32'h0, 32'h0, 32'h1002, 2'b10, 0);
      capture(); exp_ret++;
      wait_load(3, 32'h12F4_5678, stalls);
      tests++; if ({we_1, wdata_1} !== {1'b1, 32'h0000_00F4}) begin failed++; $display("FAIL lbu got we1=%b d1=%h exp 1 000000f4", we_1, wdata_1); end
      set_slot(1, 0, 0, 0, 5'd8, 5'd0, 32'h0, 32'h0, 32'h1002, 2'b01, 0);
      capture(); exp_ret++;
      wait_load(2, 32'h12F4_5678, stalls);
      tests++; if ({we_1, waddr_1, wdata_1} !== {1'b1, 5'd8, 32'h0000_12F4}) begin failed++; $display("FAIL lh_off2 got we1=%b a1=%0d d1=%h exp 1 8 000012f4", we_1, waddr_1, wdata_1); end
      tests++; if (retired !== 32'(exp_ret)) begin failed++; $display("FAIL load_retired got %0d exp %0d", retired, exp_ret); end
   endtask

   task automatic test_load_r0();
      set_slot(1, 0, 0, 0, 5'd0, 5'd5, 32'h0, 32'h100, 32'h2000, 2'b00, 0);
      capture(); exp_ret++;
      wait_load(1, 32'hAAAA_BBBB, stalls);
      tests++; if (stalls != 1) begin failed++; $display("FAIL r0_min_latency got %0d stall cycles exp 1", stalls); end
      tests++; if ({we_1, we_2, waddr_2, wdata_2} !== {1'b0, 1'b1, 5'd5, 32'h100}) begin failed++; $display("FAIL r0_ports got we1=%b we2=%b a2=%0d d2=%h exp 0 1 5 100", we_1, we_2, waddr_2, wdata_2); end
   endtask

   task automatic test_misaligned();
      set_slot(0, 1, 1, 0, 5'd4, 5'd6, 32'h11, 32'h22, 32'h3001, 2'b00, 0);
      capture(); exp_ret++;
      tests++; if ({exc_out, exc_cause, we_1, we_2, stall_out} !== {1'b1, 2'b01, 3'b000}) begin failed++; $display("FAIL misal_exc got exc=%b cause=%b we1=%b we2=%b stall=%b exp 1 01 0 0 0", exc_out, exc_cause, we_1, we_2, stall_out); end
      tests++; if (retired !== 32'(exp_ret)) begin failed++; $display("FAIL misal_retired got %0d exp %0d", retired, exp_ret); end
      @(posedge clk); #1;
      tests++; if (exc_out !== 1'b0) begin failed++; $display("FAIL misal_pulse got exc=%b exp 0", exc_out); end
   endtask

   task automatic test_timeout();
      int n;
      set_slot(1, 0, 0, 0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h4000, 2'b00, 0);
      capture(); exp_ret++;
      n = 0;
      while (stall_out === 1'b1 && n < 20) begin n++; @(posedge clk); #1; end
      tests++; if (n != 4) begin failed++; $display("FAIL tmo_stall_cycles got %0d exp 4", n); end
      tests++; if ({exc_out, exc_cause, we_1, we_2} !== {1'b1, 2'b10, 2'b00}) begin failed++; $display("FAIL tmo_exc got exc=%b cause=%b we1=%b we2=%b exp 1 10 0 0", exc_out, exc_cause, we_1, we_2); end
      set_slot(1, 0, 0, 0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h4000, 2'b00, 0);
      capture(); exp_ret++;
      wait_load(4, 32'h0BAD_F00D, stalls);
      tests++; if ({we_1, wdata_1, exc_out, stalls} !== {1'b1, 32'h0BAD_F00D, 1'b0, 32'd4}) begin failed++; $display("FAIL tmo_race got we1=%b d1=%h exc=%b stalls=%0d exp 1 0badf00d 0 4", we_1, wdata_1, exc_out, stalls); end
      tests++; if (retired !== 32'(exp_ret)) begin failed++; $display("FAIL tmo_retired got %0d exp %0d", retired, exp_ret); end
   endtask

   task automatic test_freeze();
      set_slot(0, 0, 0, 0, 5'd10, 5'd0, 32'hAA, 32'h0, 32'h0, 2'b00, 0);
      capture(); exp_ret++;
      halt = 1'b1;
      @(posedge clk); #1;
      tests++; if ({we_1, retired} !== {1'b0, 32'(exp_ret)}) begin failed++; $display("FAIL freeze_pulse got we1=%b retired=%0d exp 0 %0d", we_1, retired, exp_ret); end
      halt = 1'b0;
      set_slot(1, 0, 0, 0, 5'd11, 5'd0, 32'h0, 32'h0, 32'h5000, 2'b00, 0);
      capture(); exp_ret++;
      halt = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      tests++; if ({stall_out, we_1, exc_out} !== 3'b100) begin failed++; $display("FAIL freeze_wait got stall=%b we1=%b exc=%b exp 1 0 0", stall_out, we_1, exc_out); end
      halt = 1'b0;
      wait_load(1, 32'hCAFE_BABE, stalls);
      tests++; if ({we_1, waddr_1, wdata_1, exc_out} !== {1'b1, 5'd11, 32'hCAFE_BABE, 1'b0}) begin failed++; $display("FAIL freeze_resume got we1=%b a1=%0d d1=%h exc=%b exp 1 11 cafebabe 0", we_1, waddr_1, wdata_1, exc_out); end
   endtask

   task automatic test_halt_instr();
      set_slot(0, 0, 0, 1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 0);
      capture(); exp_ret++;
      tests++; if ({halt_out, we_1, retired} !== {1'b1, 1'b0, 32'(exp_ret)}) begin failed++; $display("FAIL halt_set got halt=%b we1=%b retired=%0d exp 1 0 %0d", halt_out, we_1, retired, exp_ret); end
      set_slot(0, 0, 0, 0, 5'd9, 5'd2, 32'h77, 32'h88, 32'h0, 2'b00, 0);
      capture();
      tests++; if ({we_1, we_2, retired} !== {2'b00, 32'(exp_ret)}) begin failed++; $display("FAIL halt_blocks got we1=%b we2=%b retired=%0d exp 0 0 %0d", we_1, we_2, retired, exp_ret); end
   endtask

   task automatic test_reset_in_wait();
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      set_slot(1, 0, 0, 0, 5'd12, 5'd0, 32'h0, 32'h0, 32'h6000, 2'b00, 0);
      capture();
      tests++; if (stall_out !== 1'b1) begin failed++; $display("FAIL rstwait_enter got stall=%b exp 1", stall_out); end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if ({stall_out, we_1, we_2, exc_out, halt_out, retired} !== '0) begin failed++; $display("FAIL rstwait_clear got stall=%b we1=%b we2=%b exc=%b halt=%b retired=%0d exp all 0", stall_out, we_1, we_2, exc_out, halt_out, retired); end
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      tests++; if ({we_1, stall_out, retired} !== {2'b00, 32'd0}) begin failed++; $display("FAIL rstwait_dropped got we1=%b stall=%b retired=%0d exp 0 0 0", we_1, stall_out, retired); end
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
      clear_slot();
      test_reset();
      test_alu();
      test_load_align();
      test_load_r0();
      test_misaligned();
      test_timeout();
      test_freeze();
      test_halt_instr();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Consumes the memory stage's registered outputs plus data-memory read responses.
- Waits for load data, aligns and sign-extends it, and drives two register-file write ports.
- Reports misaligned-access and bus-timeout exceptions, retires halts, and counts retired instructions.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before declaring a bus error (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
halt  in  1  global freeze; all state holds while high
bubble_in  in  1  memory-stage slot is empty
halt_in  in  1  slot holds a halt instruction
opcode_in  in  5  opcode of slot
tgt_in_1  in  5  primary destination register
tgt_in_2  in  5  secondary destination register (address writeback)
result_in_1  in  32  primary result (ignored for loads)
result_in_2  in  32  secondary result
addr_in  in  32  effective address
is_load  in  1  slot is a load
is_store  in  1  slot is a store
is_misaligned  in  1  access is misaligned
size_in  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word)
sign_in  in  1  sign-extend sub-word load data
mem_rdata  in  32  data-memory read data
mem_rvalid  in  1  mem_rdata valid this cycle
stall_out  out  1  freeze memory stage and everything upstream
we_1  out  1  write enable, port 1
waddr_1  out  5  write address, port 1
wdata_1  out  32  write data, port 1
we_2  out  1  write enable, port 2
waddr_2  out  5  write address, port 2
wdata_2  out  32  write data, port 2
exc_out  out  1  one-cycle exception pulse
exc_cause  out  2  01 misaligned, 10 bus timeout, 00 none
halt_out  out  1  sticky; processor halted
retired  out  32  count of retired non-bubble instructions

Behaviour:
- Reset values (all sampled on posedge clk with rst=1, regardless of halt): all outputs 0; state IDLE; timeout counter 0; captured slot marked bubble.
- States: IDLE, WAIT.
- Capture: in IDLE with halt=0, slot inputs are registered every edge. Slot is valid when bubble_in=0 and halt_out=0; otherwise it is treated as a bubble.
- Non-load valid slot, captured at edge N:
  - Outputs are registered and asserted for exactly the cycle after N.
  - we_1 = (tgt_in_1 != 0) && !is_store && !is_misaligned; wdata_1 = result_in_1.
  - we_2 = (tgt_in_2 != 0) && !is_misaligned; wdata_2 = result_in_2.
  - retired increments by 1.
- Valid load slot, not misaligned:
  - Enters WAIT at the capture edge; stall_out = (state == WAIT), purely registered.
  - mem_rvalid is sampled only in WAIT. On the first edge where it is 1, the aligned data drives wdata_1, we_1 = (tgt != 0), and port 2 is written as for non-loads.
  - On that edge: retired +1, state returns to IDLE, stall_out falls the next cycle.
  - Minimum load latency is 2 edges from capture to write-port assertion.
- Alignment, little-endian, off = addr[1:0]:
  - Word: mem_rdata.
  - Half: off[1] ? [31:16] : [15:0].
  - Byte: bits [8*off+7 : 8*off].
  - Sub-word data is zero-extended, or sign-extended when sign_in=1.
- Misaligned valid slot: no WAIT; no register writes on either port; exc_out=1, exc_cause=01 for one cycle; retired +1.
- Timeout:
  - The counter clears on WAIT entry and increments each WAIT cycle with mem_rvalid=0.
  - When it reaches TIMEOUT: exc_out=1, exc_cause=10 for one cycle, no writes, retired +1, return to IDLE.
  - mem_rvalid on the same edge as the timeout wins: normal completion, no exception.
- Halt instruction: a valid slot with halt_in=1 sets halt_out (sticky until rst) and retires; all later slots are bubbles.
- halt=1 freezes state, counters, captured slot and the timeout counter. Write enables and exc_out are forced 0 during freeze so that no pulse is duplicated.
- Bubble slots produce no writes, no exceptions and no count.
- rst in WAIT: immediate return to IDLE, stall_out=0, pending load dropped.
- retired wraps 0xFFFFFFFF -> 0.

Test Plan:
- Reset then ALU slot (tgt_in_1=3, result_in_1=0x1234, tgt_in_2=0) -> one cycle later we_1=1, waddr_1=3, wdata_1=0x1234, we_2=0; retired=1.
- Byte load, addr=0x...2, sign_in=1, mem_rvalid 3 cycles after capture, mem_rdata=0x12F4_5678 -> stall_out high 3 cycles, then wdata_1=0xFFFF_FFF4; with sign_in=0 -> 0x0000_00F4; half, off=2 -> 0x0000_12F4.
- Load to r0 with tgt_in_2=5, result_in_2=0x100 -> we_1=0, we_2=1 with wdata_2=0x100 on completion.
- Misaligned word store -> exc_out pulse, exc_cause=01, we_1=we_2=0, no stall.
- Load with mem_rvalid never asserted, TIMEOUT=4 -> stall 4 cycles, exc_cause=10, return IDLE; repeat with rvalid on the 4th cycle -> normal write, no exception.
- Halt slot followed by ALU slot -> halt_out=1, second slot produces no write and retired stays; assert rst during a WAIT -> all outputs 0 next cycle.
